// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl_pkg
// Brief   : Shared size codes, default geometry, FSM states and lane helpers
//           for the data memory controller.
// Revision: 1.0 - initial release
// ============================================================================
package data_mem_ctrl_pkg;

   localparam int CPU_WIDTH           = 32;
   localparam int DATA_MEM_ADDR_DEPTH = 4096;
   localparam int DATA_MEM_ADDR_WIDHT = 32;

   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_H = 2'b01;
   localparam logic [1:0] MEM_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
      case (size)
         MEM_SIZE_B: byte_strobe = 4'b0001 << off;
         MEM_SIZE_H: byte_strobe = 4'b0011 << off;
         default:    byte_strobe = 4'b1111;
      endcase
   endfunction

   // Right-aligned store data is copied to every lane so the strobes pick it up.
   function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
      case (size)
         MEM_SIZE_B: lane_replicate = {4{d[7:0]}};
         MEM_SIZE_H: lane_replicate = {2{d[15:0]}};
         default:    lane_replicate = d;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ram.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ram
// Brief   : DEPTH x DATA_WIDTH data RAM, per-byte write enables, registered
//           read port, array not reset.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int ADDR_W     = 12
)(
   input  logic                    clk,
   input  logic [DATA_WIDTH/8-1:0] we,
   input  logic                    re,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (we[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) begin
         r_rdata <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : req/gnt/rvalid data memory controller with sized, extended and
//           strobed accesses, error detection and configurable wait states.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = CPU_WIDTH,
   parameter int DEPTH       = DATA_MEM_ADDR_DEPTH,
   parameter int ADDR_WIDTH  = DATA_MEM_ADDR_WIDHT,
   parameter int WAIT_CYCLES = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic                  busy_o
);

   localparam int                    c_ram_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-3:0] c_depth_lim = (ADDR_WIDTH-2)'(DEPTH);
   localparam logic [3:0]            c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t r_state, w_state_next;
   logic [3:0] r_cnt, w_cnt_next;

   logic                w_in_err;
   logic [3:0]          w_in_be;
   logic [31:0]         w_in_wdata;
   logic [c_ram_aw-1:0] w_in_idx;

   logic                w_commit;
   logic                w_acc_we, w_acc_err, w_acc_uns;
   logic [1:0]          w_acc_size, w_acc_off;
   logic [3:0]          w_acc_be;
   logic [31:0]         w_acc_wdata;
   logic [c_ram_aw-1:0] w_acc_idx;

   logic        r_resp_zero, r_resp_err, r_resp_uns;
   logic [1:0]  r_resp_size, r_resp_off;

   logic [3:0]  w_ram_we;
   logic        w_ram_re;
   logic [31:0] w_ram_rdata;
   logic [31:0] w_shift;
   logic [31:0] w_load_fmt;

   assign gnt_o = req_i & ((r_state == ST_IDLE) | (r_state == ST_RESP));

   assign w_in_err = (size_i == 2'b11)
                   | ((size_i == MEM_SIZE_H) & addr_i[0])
                   | ((size_i == MEM_SIZE_W) & (addr_i[1:0] != 2'b00))
                   | (addr_i[ADDR_WIDTH-1:2] >= c_depth_lim);
   assign w_in_be    = byte_strobe(size_i, addr_i[1:0]);
   assign w_in_wdata = lane_replicate(size_i, wdata_i);
   assign w_in_idx   = addr_i[c_ram_aw+1:2];

   // The RAM access happens on the edge entering RESP; with no wait states that
   // is the grant edge itself, so the live inputs feed the RAM directly.
   generate
      if (WAIT_CYCLES == 0) begin : g_direct
         assign w_commit    = gnt_o & rst_n;
         assign w_acc_we    = we_i;
         assign w_acc_err   = w_in_err;
         assign w_acc_uns   = unsigned_i;
         assign w_acc_size  = size_i;
         assign w_acc_off   = addr_i[1:0];
         assign w_acc_be    = w_in_be;
         assign w_acc_wdata = w_in_wdata;
         assign w_acc_idx   = w_in_idx;
      end else begin : g_latched
         logic                r_we, r_err, r_uns;
         logic [1:0]          r_size, r_off;
         logic [3:0]          r_be;
         logic [31:0]         r_wdata;
         logic [c_ram_aw-1:0] r_idx;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_we    <= 1'b0;
               r_err   <= 1'b0;
               r_uns   <= 1'b0;
               r_size  <= MEM_SIZE_W;
               r_off   <= 2'b00;
               r_be    <= 4'b0000;
               r_wdata <= '0;
               r_idx   <= '0;
            end else if (gnt_o) begin
               r_we    <= we_i;
               r_err   <= w_in_err;
               r_uns   <= unsigned_i;
               r_size  <= size_i;
               r_off   <= addr_i[1:0];
               r_be    <= w_in_be;
               r_wdata <= w_in_wdata;
               r_idx   <= w_in_idx;
            end
         end

         assign w_commit    = (r_state == ST_WAIT) && (r_cnt == 4'd0);
         assign w_acc_we    = r_we;
         assign w_acc_err   = r_err;
         assign w_acc_uns   = r_uns;
         assign w_acc_size  = r_size;
         assign w_acc_off   = r_off;
         assign w_acc_be    = r_be;
         assign w_acc_wdata = r_wdata;
         assign w_acc_idx   = r_idx;
      end
   endgenerate

   assign w_ram_we = w_acc_be & {4{w_commit & w_acc_we & ~w_acc_err}};
   assign w_ram_re = w_commit & ~w_acc_we & ~w_acc_err;

   data_mem_ram #(
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .ADDR_W     (c_ram_aw)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .re    (w_ram_re),
      .addr  (w_acc_idx),
      .wdata (w_acc_wdata),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE, ST_RESP: begin
            if (gnt_o) begin
               if (WAIT_CYCLES > 0) begin
                  w_state_next = ST_WAIT;
                  w_cnt_next   = c_wait_load;
               end else begin
                  w_state_next = ST_RESP;
               end
            end else if (r_state == ST_RESP) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_next = ST_RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Response attributes are frozen with the RAM read so rdata_o holds until
   // the next response even if a new request is granted meanwhile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_zero <= 1'b1;
         r_resp_err  <= 1'b0;
         r_resp_uns  <= 1'b0;
         r_resp_size <= MEM_SIZE_W;
         r_resp_off  <= 2'b00;
      end else if (w_commit) begin
         r_resp_zero <= w_acc_we | w_acc_err;
         r_resp_err  <= w_acc_err;
         r_resp_uns  <= w_acc_uns;
         r_resp_size <= w_acc_size;
         r_resp_off  <= w_acc_off;
      end
   end

   assign w_shift = w_ram_rdata >> {r_resp_off, 3'b000};

   always_comb begin
      w_load_fmt = w_ram_rdata;
      case (r_resp_size)
         MEM_SIZE_B: w_load_fmt = {{24{~r_resp_uns & w_shift[7]}}, w_shift[7:0]};
         MEM_SIZE_H: w_load_fmt = {{16{~r_resp_uns & w_shift[15]}}, w_shift[15:0]};
         default:    w_load_fmt = w_ram_rdata;
      endcase
   end

   assign rdata_o  = r_resp_zero ? '0 : w_load_fmt;
   assign err_o    = r_resp_err;
   assign rvalid_o = (r_state == ST_RESP);
   assign busy_o   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Brief   : Directed vector bench for data_mem_ctrl (one wait state and zero
//           wait state instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

   localparam int W1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        req1, we1, uns1, gnt1, rvalid1, err1, busy1;
   logic [1:0]  size1;
   logic [31:0] addr1, wdata1, rdata1;
   logic        req0, we0, uns0, gnt0, rvalid0, err0, busy0;
   logic [1:0]  size0;
   logic [31:0] addr0, wdata0, rdata0;

   data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(4096), .ADDR_WIDTH(32), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_i(req1), .we_i(we1), .size_i(size1),
      .unsigned_i(uns1), .addr_i(addr1), .wdata_i(wdata1), .gnt_o(gnt1),
      .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
   );

   data_mem_ctrl #(.DATA_WIDTH(32), .DEPTH(4096), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .size_i(size0),
      .unsigned_i(uns0), .addr_i(addr0), .wdata_i(wdata0), .gnt_o(gnt0),
      .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0), .busy_o(busy0)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic access1(input vec_t v);
      int n;
      @(negedge clk);
      req1 = 1'b1; we1 = v.we; size1 = v.size; uns1 = v.uns;
      addr1 = v.addr; wdata1 = v.wdata;
      #1 check({v.name, " gnt"}, 32'(gnt1), 32'd1);
      @(negedge clk);
      // inputs after the grant cycle must be ignored
      req1 = 1'b0; we1 = ~v.we; size1 = 2'b11; addr1 = 32'hFFFF_FFFC; wdata1 = 32'hA5A5_A5A5;
      n = 1;
      while (!rvalid1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({v.name, " latency"}, 32'(n), 32'(W1 + 1));
      check({v.name, " rdata"}, rdata1, v.exp_rdata);
      check({v.name, " err"}, 32'(err1), 32'(v.exp_err));
      @(negedge clk);
      check({v.name, " rvalid one cycle"}, 32'(rvalid1), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0, "SW 100"});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0, "LW 100"});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h103,  32'h0,        32'hFFFFFFDE, 1'b0, "LB 103"});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h103,  32'h0,        32'h000000DE, 1'b0, "LBU 103"});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h100,  32'h0,        32'hFFFFBEEF, 1'b0, "LH 100"});
      vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h102,  32'h0,        32'h0000DEAD, 1'b0, "LHU 102"});
      vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h101,  32'h00000055, 32'h0,        1'b0, "SB 101"});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        32'hDEAD55EF, 1'b0, "LW after SB"});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h101,  32'h0,        32'h00000055, 1'b0, "LB 101"});
      vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h101,  32'h00001234, 32'h0,        1'b1, "SH 101 misaligned"});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        32'hDEAD55EF, 1'b0, "LW after bad SH"});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h4000, 32'h0,        32'h0,        1'b1, "LW 4000 range"});
      vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h100,  32'h0,        32'h0,        1'b1, "size 11"});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h102,  32'h0,        32'h0,        1'b1, "LW 102 misaligned"});
      vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h3FFF, 32'h00000080, 32'h0,        1'b0, "SB 3FFF top"});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h3FFF, 32'h0,        32'hFFFFFF80, 1'b0, "LB 3FFF"});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h3FFF, 32'h0,        32'h00000080, 1'b0, "LBU 3FFF"});

      rst_n = 1'b0;
      req1 = 0; we1 = 0; size1 = 0; uns1 = 0; addr1 = 0; wdata1 = 0;
      req0 = 0; we0 = 0; size0 = 0; uns0 = 0; addr0 = 0; wdata0 = 0;
      repeat (3) @(negedge clk);
      check("reset rvalid", 32'(rvalid1), 32'd0);
      check("reset err",    32'(err1),    32'd0);
      check("reset rdata",  rdata1,       32'd0);
      check("reset busy",   32'(busy1),   32'd0);
      check("reset gnt",    32'(gnt1),    32'd0);
      check("reset0 rdata", rdata0,       32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         access1(vecs[i]);
      end

      // Reset during the WAIT cycle of a store: aborted, no response
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; size1 = 2'b10; uns1 = 1'b0; addr1 = 32'h100; wdata1 = 32'h0;
      @(negedge clk);
      req1 = 1'b0;
      check("mid busy before reset", 32'(busy1), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid reset rvalid", 32'(rvalid1), 32'd0);
      check("mid reset busy",   32'(busy1),   32'd0);
      check("mid reset rdata",  rdata1,       32'd0);
      check("mid reset err",    32'(err1),    32'd0);
      @(negedge clk);
      check("mid reset rvalid hold", 32'(rvalid1), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post reset rvalid", 32'(rvalid1), 32'd0);
      access1('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD55EF, 1'b0, "LW after aborted SW"});

      // Zero wait states: load granted in the store's RESP cycle
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; uns0 = 1'b0; addr0 = 32'h200; wdata0 = 32'h12345678;
      #1 check("b2b SW gnt", 32'(gnt0), 32'd1);
      @(negedge clk);
      check("b2b SW rvalid", 32'(rvalid0), 32'd1);
      check("b2b SW rdata",  rdata0,       32'd0);
      check("b2b SW err",    32'(err0),    32'd0);
      we0 = 1'b0; wdata0 = 32'h0;
      #1 check("b2b LW gnt in RESP", 32'(gnt0), 32'd1);
      @(negedge clk);
      req0 = 1'b0;
      check("b2b LW rvalid", 32'(rvalid0), 32'd1);
      check("b2b LW rdata",  rdata0,       32'h12345678);
      check("b2b LW err",    32'(err0),    32'd0);
      @(negedge clk);
      check("b2b idle rvalid", 32'(rvalid0), 32'd0);
      check("b2b idle busy",   32'(busy0),   32'd0);
      check("b2b rdata hold",  rdata0,       32'h12345678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
